// File: rtl/keccak_pkg.sv
// Shared Keccak/SHAKE core definitions: datapath width, rate block depths
// and the load-side sequencer state type.
package keccak_pkg;

    localparam int W = 64;

    // Rate block depth in words: SHAKE128 rate is 168 bytes, SHAKE256 is 136 bytes.
    localparam int SHAKE128_DEPTH = 21;
    localparam int SHAKE256_DEPTH = 17;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        PAD   = 2'd2,
        BLOCK = 2'd3
    } load_ctrl_state_t;

endpackage

// File: rtl/load_controller.sv
// Absorb-side load sequencer: takes a header then message words, drives the
// load datapath enables and hands completed rate blocks to the permutation.
module load_controller
    import keccak_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic valid_in,
    output logic ready_in,
    input  logic absorb_ready,
    output logic absorb_valid,
    output logic last_block_out,
    output logic busy,
    output logic load_enable,
    output logic control_regs_enable,
    output logic padding_enable,
    output logic padding_reset,
    output logic input_counter_en,
    output logic input_counter_load,
    input  logic input_size_reached,
    input  logic input_buffer_full,
    input  logic last_input_block,
    input  logic first_incomplete_input_word
);

    load_ctrl_state_t state;
    load_ctrl_state_t state_nxt;

    logic load_ready;
    logic load_accept;

    assign load_ready  = !input_buffer_full && !input_size_reached;
    assign load_accept = valid_in && load_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A full buffer takes priority over end of message so the block is
    // presented before any padding-only continuation.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (valid_in) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (input_buffer_full) begin
                    state_nxt = BLOCK;
                end else if (input_size_reached) begin
                    state_nxt = PAD;
                end
            end
            PAD: begin
                if (input_buffer_full) begin
                    state_nxt = BLOCK;
                end
            end
            BLOCK: begin
                if (absorb_ready) begin
                    if (last_input_block) begin
                        state_nxt = IDLE;
                    end else if (input_size_reached) begin
                        state_nxt = PAD;
                    end else begin
                        state_nxt = LOAD;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are forced low while rst is held, including ready_in in IDLE.
    always_comb begin
        ready_in            = 1'b0;
        absorb_valid        = 1'b0;
        last_block_out      = 1'b0;
        busy                = 1'b0;
        load_enable         = 1'b0;
        control_regs_enable = 1'b0;
        padding_enable      = 1'b0;
        padding_reset       = 1'b0;
        input_counter_en    = 1'b0;
        input_counter_load  = 1'b0;
        if (!rst) begin
            busy = (state != IDLE);
            case (state)
                IDLE: begin
                    ready_in = 1'b1;
                    if (valid_in) begin
                        control_regs_enable = 1'b1;
                        input_counter_load  = 1'b1;
                        padding_reset       = 1'b1;
                    end
                end
                LOAD: begin
                    ready_in = load_ready;
                    if (load_accept) begin
                        load_enable      = 1'b1;
                        input_counter_en = 1'b1;
                        padding_enable   = first_incomplete_input_word;
                    end
                end
                PAD: begin
                    // The cycle that sees the buffer full only moves on to BLOCK.
                    if (!input_buffer_full) begin
                        load_enable      = 1'b1;
                        padding_enable   = 1'b1;
                        input_counter_en = 1'b1;
                    end
                end
                BLOCK: begin
                    absorb_valid       = 1'b1;
                    last_block_out     = last_input_block;
                    input_counter_load = absorb_ready;
                end
                default: begin
                    ready_in = 1'b0;
                end
            endcase
        end
    end

endmodule
